// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: FSM states, counter sizing and divide-by-zero constant for seq_divider.
package seq_divider_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int CNT_W = $clog2(DEF_WIDTH) + 1;
  localparam logic [63:0] DBZ_QUOT = '1;
endpackage

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: divider FSM and iteration counter, emits datapath strobes and busy/done.
module seq_divider_ctrl
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW = CNT_W
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic d_zero,
  output logic accept,
  output logic clear,
  output logic shift,
  output logic fix,
  output logic busy,
  output logic done
);
  state_t state, next;
  logic [CW-1:0] cnt;
  assign accept = state == IDLE && start;
  assign clear = state == LOAD;
  assign shift = state == ITER;
  assign fix = state == FIX;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? LOAD : IDLE;
      LOAD: next = d_zero ? FIX : ITER;
      ITER: next = cnt == CW'(1) ? FIX : ITER;
      FIX: next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= next;
      busy <= next == LOAD || next == ITER || next == FIX;
      done <= next == DONE;
    end
  end
  always_ff @(posedge clk)
    if (clear) cnt <= CW'(WIDTH);
    else if (shift) cnt <= cnt - 1'b1;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: non-restoring sequential divider, one quotient bit per clock.
// Signed operands when SEQ_DIVIDER_SIGNED_EN is defined, unsigned otherwise.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);
  logic accept, clear, shift, fix, d_zero, neg_q, neg_r;
  logic [WIDTH-1:0] q, d, mag_n, mag_d, rem_mag;
  logic [WIDTH:0] p, p_sh, p_next, p_fix;
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign mag_n = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_d = divisor[WIDTH-1] ? -divisor : divisor;
`else
  assign mag_n = dividend;
  assign mag_d = divisor;
`endif
  assign d_zero = d == '0;
  assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
  assign p_next = p[WIDTH] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
  assign p_fix = p[WIDTH] ? p + {1'b0, d} : p;
  // Without iterations Q still holds |dividend|, which re-signs back to the raw dividend.
  assign rem_mag = d_zero ? q : p_fix[WIDTH-1:0];
  seq_divider_ctrl #(.WIDTH(WIDTH), .CW($clog2(WIDTH) + 1)) u_ctrl (
    .clk(clk), .clr_n(clr_n), .start(start), .d_zero(d_zero), .accept(accept),
    .clear(clear), .shift(shift), .fix(fix), .busy(busy), .done(done)
  );
  always_ff @(posedge clk) begin
    if (accept) begin
      q <= mag_n;
      d <= mag_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
`else
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end
    if (clear) p <= '0;
    if (shift) begin
      p <= p_next;
      q <= {q[WIDTH-2:0], ~p_next[WIDTH]};
    end
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dbz <= 1'b0;
    end else if (fix) begin
      quotient <= d_zero ? DBZ_QUOT[WIDTH-1:0] : neg_q ? -q : q;
      remainder <= neg_r ? -rem_mag : rem_mag;
      dbz <= d_zero;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven directed checks of seq_divider plus reset/start corner sequences.
module tb_seq_divider;
  localparam int W = 16;
  logic clk = 1'b0, clr_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic busy, done, dbz;
  int tests = 0, fails = 0;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic dz;
    int lat;
  } vec_t;
  vec_t vecs[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for done after the accepting edge; optionally pulses start with junk operands at edge E0+glitch.
  task automatic wait_done(input int glitch, output int lat);
    logic busy_ok = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == glitch) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (k + 1 == glitch) begin
        start = 1'b1;
        dividend = 16'd99;
        divisor = 16'd2;
      end
    end
    check("busy_during_op", 32'(busy_ok), 32'd1);
  endtask

  task automatic run(input vec_t v, input int glitch, input string name);
    int lat;
    @(negedge clk);
    dividend = v.a;
    divisor = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(glitch, lat);
    check({name, "_latency"}, 32'(lat), 32'(v.lat));
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    check({name, "_quotient"}, 32'(quotient), 32'(v.q));
    check({name, "_remainder"}, 32'(remainder), 32'(v.r));
    check({name, "_dbz"}, 32'(dbz), 32'(v.dz));
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    vecs.push_back('{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18});
    vecs.push_back('{16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 2});
    vecs.push_back('{16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 18});
    vecs.push_back('{16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 18});
    vecs.push_back('{16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 18});
    vecs.push_back('{16'hFF9C, 16'd0, 16'hFFFF, 16'hFF9C, 1'b1, 2});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 18});
    vecs.push_back('{16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0, 18});
    vecs.push_back('{16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 18});
    vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 18});
`else
    vecs.push_back('{16'hFF9C, 16'd7, 16'd9348, 16'd0, 1'b0, 18});
    vecs.push_back('{16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 18});
    vecs.push_back('{16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 18});
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_busy_done_dbz", {29'd0, busy, done, dbz}, 32'd0);
    clr_n = 1'b1;
    foreach (vecs[i]) run(vecs[i], 0, $sformatf("vec%0d", i));

    // Reset at E0+8 of 1000/10 discards the operation.
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    check("midreset_outputs", {quotient, remainder} | 32'({busy, done, dbz}), 32'd0);
    begin
      logic seen = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (done) seen = 1'b1;
      end
      check("midreset_no_done", 32'(seen), 32'd0);
    end
    run('{16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 18}, 0, "after_reset");

    // start pulsed at E0+5 with other operands is ignored.
    run('{16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 18}, 5, "busy_start");

    // start held through DONE is accepted on the first IDLE edge.
    @(negedge clk);
    dividend = 16'd100;
    divisor = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, lat);
    check("held_first_latency", 32'(lat), 32'd18);
    @(posedge clk);
    #1;
    check("held_idle_gap_busy", 32'(busy), 32'd0);
    dividend = 16'd9;
    divisor = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_reaccept_busy", 32'(busy), 32'd1);
    wait_done(0, lat);
    check("held_second_latency", 32'(lat), 32'd18);
    check("held_second_quotient", 32'(quotient), 32'd3);
    check("held_second_remainder", 32'(remainder), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
